dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-ported data_memory between two requesters: the core LSU (core port) and a debug/program-loader master (dbg port).
- Sits between lsu and data_memory in core_top.
- Drives the program_counter stall input when the core loses arbitration.
- Core has default priority. A starvation counter guarantees debug progress. A burst lock lets the loader stream consecutive accesses.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles debug may be denied by core before it is force-granted one cycle. Legal range 1..15.
- MAX_BURST, 8: maximum consecutive debug grants under d_lock while core is requesting. Legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- c_read_en  in  1  core load request
- c_write_en  in  1  core store request
- c_addr  in  32  core byte address
- c_store_size  in  2  core access size: 00 byte, 01 half, 10 word
- c_wdata  in  32  core store data
- c_rdata  out  32  core load data (combinational from mem_read_data)
- c_stall  out  1  core request present but not granted this cycle
- d_req  in  1  debug access request, held until d_gnt
- d_we  in  1  debug write (1) / read (0)
- d_addr  in  32  debug byte address
- d_size  in  2  debug access size, same encoding as c_store_size
- d_wdata  in  32  debug write data
- d_lock  in  1  request burst continuation
- d_gnt  out  1  debug access performed this cycle
- d_rdata  out  32  registered debug read data
- d_rvalid  out  1  d_rdata valid, one cycle after a read grant
- mem_write_en  out  1  to data_memory
- mem_read_en  out  1  to data_memory
- mem_addr  out  32  to data_memory
- mem_store_size  out  2  to data_memory
- mem_write_data  out  32  to data_memory
- mem_read_data  in  32  from data_memory (combinational read)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Requests: c_req = c_read_en | c_write_en.
- Access timing: one memory access per cycle. Grant is combinational from the current state and counters. Stores commit at the clk edge inside data_memory.
- States:
  - CORE_PRI (reset state)
  - DBG_BURST
- CORE_PRI grant rules:
  - c_req & ~force: grant core.
  - d_req & (~c_req | force): grant debug.
  - force = (starve_cnt == STARVE_LIMIT).
- DBG_BURST grant rules:
  - If d_req & d_lock & (~c_req | burst_cnt < MAX_BURST): grant debug.
  - Otherwise behave as CORE_PRI, except that force is ignored.
- Transitions:
  - CORE_PRI -> DBG_BURST on a debug grant with d_lock=1. burst_cnt <= 1.
  - DBG_BURST: each further debug grant increments burst_cnt, saturating at 255, but only when c_req=1. Any cycle without a debug grant returns the FSM to CORE_PRI and sets burst_cnt <= 0.
- starve_cnt (4-bit):
  - Increments when d_req & c_req & ~d_gnt.
  - Clears on any d_gnt, or when d_req=0.
  - Saturates at STARVE_LIMIT.
- Outputs by grant:
  - Core granted: mem_* driven from c_*; c_stall = 0.
  - Debug granted: mem_* driven from d_*; mem_write_en = d_we, mem_read_en = ~d_we; c_stall = c_req.
  - No grant: mem_write_en = 0, mem_read_en = 0, mem_addr = 0, mem_store_size = 0, mem_write_data = 0, c_stall = 0.
- c_rdata = mem_read_data at all times. It is meaningful only when the core is granted.
- Debug read response: on a debug read grant, d_rdata <= mem_read_data and d_rvalid <= 1 next cycle. Otherwise d_rvalid <= 0 and d_rdata holds.
- Reset: state CORE_PRI, starve_cnt 0, burst_cnt 0, d_rvalid 0, d_rdata 0. While reset=1: no grants, all mem enables 0, c_stall 0, d_gnt 0. A burst in progress is abandoned. The debug master must re-request.
- Boundary cases:
  - Simultaneous c_req and d_req with starve_cnt < STARVE_LIMIT: core wins.
  - Exactly at the limit: debug wins one cycle, then starve_cnt clears.
  - Deasserting d_lock mid-burst ends the burst the next cycle. That cycle follows CORE_PRI rules.
  - d_req deasserted while stalled: no grant, counters clear.
  - Core store and debug read to the same address in consecutive cycles: the debug read sees the stored value (memory ordering equals grant order).

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- With the macro defined, two extra outputs are added:
  - stat_core_stall_cnt [31:0]: counts cycles with c_stall = 1.
  - stat_dbg_wait_cnt [31:0]: counts cycles with d_req & ~d_gnt.
  - Both are cleared by reset and wrap modulo 2^32.
- Without the macro, the ports and counters do not exist. Arbitration behaviour is identical in both builds.

Test Plan:
- Core only: c_write_en, addr 0x10, word 0xDEADBEEF; then c_read_en, addr 0x10 -> c_stall 0 both cycles, c_rdata 0xDEADBEEF on the read cycle.
- Debug only: d_req read, addr 0x10, core idle -> d_gnt same cycle; next cycle d_rvalid 1, d_rdata 0xDEADBEEF.
- Starvation: c_req and d_req held high, STARVE_LIMIT=4 -> core granted cycles 0-3, d_gnt on cycle 4 with c_stall 1, core resumes cycle 5.
- Burst: d_lock=1, continuous c_req and d_req, MAX_BURST=8 -> after the first forced grant, debug granted through burst_cnt=8, then core granted; FSM back in CORE_PRI.
- Reset mid-burst: reset asserted on the 3rd burst cycle -> that cycle mem enables 0, d_gnt 0, d_rvalid 0 next cycle; after reset, a lone c_req is granted immediately.
- Stats build: 10 cycles of conflict with STARVE_LIMIT=4 -> stat_core_stall_cnt 2, stat_dbg_wait_cnt 8.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-master arbiter (core LSU / debug loader) for the single
//               ported data memory. Core has default priority; a starvation
//               counter and a debug burst lock guarantee loader progress.
//               Optional macro DMEM_ARB_STATS_EN adds stall/wait counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_BURST    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_read_en,
    input  logic        c_write_en,
    input  logic [31:0] c_addr,
    input  logic [1:0]  c_store_size,
    input  logic [31:0] c_wdata,
    output logic [31:0] c_rdata,
    output logic        c_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    input  logic        d_lock,
    output logic        d_gnt,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        mem_write_en,
    output logic        mem_read_en,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_store_size,
    output logic [31:0] mem_write_data,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0] stat_core_stall_cnt,
    output logic [31:0] stat_dbg_wait_cnt,
`endif
    input  logic [31:0] mem_read_data
);

    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [7:0] C_MAX_BURST    = 8'(MAX_BURST);
    localparam logic [7:0] C_BURST_SAT    = 8'd255;

    typedef enum logic [0:0] {
        CORE_PRI  = 1'b0,
        DBG_BURST = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_nxt;
    logic [7:0] r_burst_cnt;
    logic [7:0] w_burst_nxt;

    logic w_c_req;
    logic w_force;
    logic w_burst_ok;
    logic w_gnt_c;
    logic w_gnt_d;

    assign w_c_req    = c_read_en | c_write_en;
    assign w_force    = (r_starve_cnt == C_STARVE_LIMIT);
    assign w_burst_ok = d_req & d_lock & (~w_c_req | (r_burst_cnt < C_MAX_BURST));

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        w_gnt_c = 1'b0;
        w_gnt_d = 1'b0;
        if (!reset) begin
            case (r_state)
                DBG_BURST: begin
                    if (w_burst_ok || (d_req && !w_c_req)) begin
                        w_gnt_d = 1'b1;
                    end else if (w_c_req) begin
                        w_gnt_c = 1'b1;
                    end
                end
                default: begin
                    if (d_req && (!w_c_req || w_force)) begin
                        w_gnt_d = 1'b1;
                    end else if (w_c_req) begin
                        w_gnt_c = 1'b1;
                    end
                end
            endcase
        end
    end

    // Burst tracking: the burst survives only on locked debug grants.
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        case (r_state)
            DBG_BURST: begin
                if (w_gnt_d && d_lock) begin
                    if (w_c_req && (r_burst_cnt != C_BURST_SAT)) begin
                        w_burst_nxt = r_burst_cnt + 8'd1;
                    end
                end else begin
                    w_state_nxt = CORE_PRI;
                    w_burst_nxt = 8'd0;
                end
            end
            default: begin
                if (w_gnt_d && d_lock) begin
                    w_state_nxt = DBG_BURST;
                    w_burst_nxt = 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_gnt_d || !d_req) begin
            w_starve_nxt = 4'd0;
        end else if (w_c_req && (r_starve_cnt != C_STARVE_LIMIT)) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= CORE_PRI;
            r_starve_cnt <= 4'd0;
            r_burst_cnt  <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_burst_cnt  <= w_burst_nxt;
        end
    end

    always_comb begin
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        mem_addr       = 32'd0;
        mem_store_size = 2'd0;
        mem_write_data = 32'd0;
        c_stall        = 1'b0;
        if (w_gnt_c) begin
            mem_write_en   = c_write_en;
            mem_read_en    = c_read_en;
            mem_addr       = c_addr;
            mem_store_size = c_store_size;
            mem_write_data = c_wdata;
        end else if (w_gnt_d) begin
            mem_write_en   = d_we;
            mem_read_en    = ~d_we;
            mem_addr       = d_addr;
            mem_store_size = d_size;
            mem_write_data = d_wdata;
            c_stall        = w_c_req;
        end
    end

    assign d_gnt   = w_gnt_d;
    assign c_rdata = mem_read_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_rvalid <= 1'b0;
            d_rdata  <= 32'd0;
        end else begin
            d_rvalid <= w_gnt_d & ~d_we;
            if (w_gnt_d && !d_we) begin
                d_rdata <= mem_read_data;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_core_stall_cnt <= 32'd0;
            stat_dbg_wait_cnt   <= 32'd0;
        end else begin
            stat_core_stall_cnt <= stat_core_stall_cnt + {31'd0, c_stall};
            stat_dbg_wait_cnt   <= stat_dbg_wait_cnt + {31'd0, d_req & ~w_gnt_d};
        end
    end
`endif

endmodule

`default_nettype wire
